serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: start  input  1  request to begin an addition.
REQ-005 SHALL provide port: a  input  WIDTH  operand A, sampled on accepted start.
REQ-006 SHALL provide port: b  input  WIDTH  operand B, sampled on accepted start.
REQ-007 SHALL provide port: cin  input  1  carry-in, sampled on accepted start.
REQ-008 SHALL provide port: busy  output  1  high while bits are being processed.
REQ-009 SHALL provide port: done  output  1  one-cycle pulse: result valid.
REQ-010 SHALL provide port: sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
REQ-011 SHALL provide port: cout  output  1  registered carry out of bit WIDTH-1.
REQ-012 SHALL use one clock and a synchronous, active-high reset; no other clock or async path.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 In IDLE, start=1 SHALL be accepted at the clock edge: load a, b into shift registers, cin into carry flop, clear bit counter, go to SHIFT.
REQ-015 start SHALL be ignored in SHIFT and DONE; operand inputs SHALL not affect an operation in progress.
REQ-016 In SHIFT, each cycle SHALL process one bit, LSB first, with full-adder logic: s = a0^b0^c, c_next = a0&b0 | c&(a0^b0).
REQ-017 Each SHIFT cycle SHALL shift both operand registers right by one and shift s into the MSB of a partial-result register.
REQ-018 A log2-sized bit counter SHALL count 0..WIDTH-1; after the cycle with counter=WIDTH-1, the FSM SHALL go to DONE.
REQ-019 busy SHALL be 1 exactly in SHIFT: for WIDTH cycles starting the cycle after start is accepted.
REQ-020 On entry to DONE, sum SHALL load the full partial-result register and cout the final carry; done=1 for exactly that one cycle; next state IDLE.
REQ-021 Latency: start accepted at edge k -> done high in cycle k+WIDTH+1; minimum start-to-start spacing WIDTH+2 cycles.
REQ-022 sum and cout SHALL hold their values from DONE until the next DONE or reset.
REQ-023 Overflow SHALL be reported only via cout; sum wraps modulo 2^WIDTH.
REQ-024 start asserted continuously SHALL produce back-to-back operations, one per WIDTH+2 cycles, each sampling the operands present in IDLE.

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry flop, and all shift registers.
REQ-026 rst SHALL take priority over start and over any in-progress SHIFT; an aborted operation SHALL produce no done pulse.
REQ-027 The first start after rst deasserts SHALL be accepted in the first cycle rst is low.

Verification
REQ-028 WIDTH=8, a=0x35, b=0x4A, cin=0, start pulse -> busy high 8 cycles; done pulse in the 9th cycle after start; sum=0x7F, cout=0.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 start=1 with new operands while busy=1 -> ignored; result matches the originally accepted operands; exactly one done.
REQ-031 rst pulsed during the 4th SHIFT cycle -> next cycle busy=0, sum=0, cout=0, no done; a fresh start then completes normally.
REQ-032 start held high across two operations (0x10+0x20, then 0x7F+0x01) -> done pulses spaced 10 cycles apart; sums 0x30 then 0x80, cout=0 for both.
REQ-033 Randomized: 1000 operations with random a, b, cin -> {cout,sum} equals a+b+cin for each.

Source files
------------

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder. The adder accepts one operand pair, processes one
// bit per clock with a single full adder (LSB first), and then presents the
// registered result with a one-cycle done pulse.
//
// Parameters
//    WIDTH  operand/result width in bits (2..32)
//
// Ports
//    clk    single clock, all state changes on the rising edge
//    rst    synchronous active-high reset
//    start  begin an addition (honoured only while idle)
//    a, b   operands, captured when start is accepted
//    cin    carry-in, captured when start is accepted
//    busy   high during the WIDTH bit-processing cycles
//    done   one-cycle pulse when sum/cout have just been updated
//    sum    registered (a+b+cin) mod 2^WIDTH, held until the next result
//    cout   registered carry out of the top bit, held with sum
// ---------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LASTBIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;

   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] preg;
   logic [WIDTH-1:0] preg_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sbit;
   logic             cnext;
   logic             lastbit;

   // One full adder on the current least-significant operand bits. The new
   // sum bit enters the partial result from the top, so after WIDTH shifts
   // the first (LSB) result bit has arrived at bit 0.
   always_comb begin
      sbit      = areg[0] ^ breg[0] ^ carry;
      cnext     = (areg[0] & breg[0]) | (carry & (areg[0] ^ breg[0]));
      preg_next = {sbit, {(WIDTH-1){1'b0}}} | (preg >> 1);
      lastbit   = (cnt == LASTBIT);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and the status outputs, which are decoded straight
   // from the registered state so they are glitch-free.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (lastbit) begin
               next_state = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath. Operands are only captured in IDLE, so new inputs or a
   // repeated start during an operation cannot disturb it. The result
   // registers are written on the same edge that enters DONE, using the
   // partial result including the final bit, so they are valid together
   // with done and then simply hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         areg  <= '0;
         breg  <= '0;
         preg  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  areg  <= a;
                  breg  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               areg  <= areg >> 1;
               breg  <= breg >> 1;
               preg  <= preg_next;
               carry <= cnext;
               cnt   <= cnt + CW'(1);
               if (lastbit) begin
                  sum  <= preg_next;
                  cout <= cnext;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH = 8). The stimulus side pushes
// the arithmetic result a+b+cin of every operation it expects the adder to
// accept into a queue; an independent monitor pops and compares {cout,sum}
// whenever done is seen. Timing (latency, busy length, start-to-start
// spacing) and reset behaviour are checked by the stimulus side.
// ---------------------------------------------------------------------------
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int checks;
   int errors;
   int donecount;

   logic [WIDTH:0] expq[$];

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: plain integer addition.
   function automatic logic [WIDTH:0] refAdd(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c);
      return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
   endfunction

   function automatic void checkOutput(input string name,
                                       input logic [31:0] actual,
                                       input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endfunction

   // All driving and sampling happens 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every done pulse must match the oldest outstanding result.
   initial begin
      logic [WIDTH:0] exp;
      forever begin
         @(posedge clk);
         #1;
         if (done) begin
            donecount++;
            if (expq.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp = expq.pop_front();
               checkOutput("result", {23'd0, cout, sum}, {23'd0, exp});
            end
         end
      end
   end

   // Issue one operation from IDLE and follow it to its done pulse. With
   // junk set, start stays high and the operands keep changing during the
   // first cycles of the operation, which the adder must ignore.
   task automatic applyStimulus(input logic [WIDTH-1:0] ta,
                                input logic [WIDTH-1:0] tb,
                                input logic tc,
                                input bit junk);
      int lat;
      int busyc;
      bit seen;
      a     = ta;
      b     = tb;
      cin   = tc;
      start = 1'b1;
      expq.push_back(refAdd(ta, tb, tc));
      tick();
      lat   = 0;
      busyc = 0;
      seen  = 1'b0;
      if (!junk) start = 1'b0;
      while (!seen && lat < WIDTH + 6) begin
         lat++;
         if (busy) busyc++;
         if (done) begin
            seen = 1'b1;
         end else begin
            if (junk) begin
               a   = 8'($urandom);
               b   = 8'($urandom);
               cin = 1'($urandom);
               if (lat >= 5) start = 1'b0;
            end
            tick();
         end
      end
      start = 1'b0;
      checkOutput("done_seen", 32'(seen), 32'd1);
      checkOutput("latency", 32'(lat), 32'(WIDTH + 1));
      checkOutput("busy_cycles", 32'(busyc), 32'(WIDTH));
      tick();
      checkOutput("done_one_cycle", 32'(done), 32'd0);
   endtask

   // Main stimulus sequence.
   initial begin
      int spacing;
      int waited;
      int dones;
      int startdones;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;

      checks    = 0;
      errors    = 0;
      donecount = 0;
      rst       = 1'b1;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;

      tick();
      start = 1'b1;
      a     = 8'hAA;
      b     = 8'h55;
      tick();
      start = 1'b0;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_sum", 32'(sum), 32'd0);
      checkOutput("reset_cout", 32'(cout), 32'd0);

      // First start in the first cycle reset is low.
      rst = 1'b0;
      applyStimulus(8'h35, 8'h4A, 1'b0, 1'b0);
      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
      applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);

      // Result holds while idle.
      for (int i = 0; i < 3; i++) tick();
      checkOutput("hold_sum", 32'(sum), 32'hFF);
      checkOutput("hold_cout", 32'(cout), 32'd1);

      // Start and operand changes while busy are ignored.
      startdones = donecount;
      applyStimulus(8'h12, 8'h34, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      checkOutput("single_done", 32'(donecount - startdones), 32'd1);

      // Prepare a nonzero result, then reset during the 4th SHIFT cycle.
      applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
      a     = 8'h5A;
      b     = 8'h33;
      cin   = 1'b1;
      start = 1'b1;
      expq.push_back(refAdd(8'h5A, 8'h33, 1'b1));
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checkOutput("abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      expq.delete();
      tick();
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_sum", 32'(sum), 32'd0);
      checkOutput("abort_cout", 32'(cout), 32'd0);
      rst = 1'b0;
      startdones = donecount;
      for (int i = 0; i < WIDTH + 4; i++) tick();
      checkOutput("abort_no_done", 32'(donecount - startdones), 32'd0);
      applyStimulus(8'h21, 8'h43, 1'b0, 1'b0);

      // start held high: two back-to-back operations.
      a     = 8'h10;
      b     = 8'h20;
      cin   = 1'b0;
      start = 1'b1;
      expq.push_back(refAdd(8'h10, 8'h20, 1'b0));
      tick();
      a = 8'h7F;
      b = 8'h01;
      expq.push_back(refAdd(8'h7F, 8'h01, 1'b0));
      waited  = 0;
      dones   = 0;
      spacing = 0;
      while (dones < 2 && waited < 4 * WIDTH) begin
         waited++;
         if (dones == 1) spacing++;
         if (done) dones++;
         if (dones < 2) tick();
      end
      start = 1'b0;
      checkOutput("b2b_dones", 32'(dones), 32'd2);
      checkOutput("b2b_spacing", 32'(spacing), 32'(WIDTH + 2));
      tick();

      // Randomised operations.
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         applyStimulus(ra, rb, rc, 1'b0);
      end

      for (int i = 0; i < 3; i++) tick();
      checkOutput("queue_empty", 32'(expq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
